// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a word-only data memory: read-modify-write for
// sub-word stores, lane extraction with sign/zero extension, alignment/range checks.
module mem_access_ctrl #(
   parameter int unsigned ADDR_BITS = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;

   localparam logic [1:0]  SZ_BYTE = 2'd0;
   localparam logic [1:0]  SZ_HALF = 2'd1;
   localparam logic [1:0]  SZ_WORD = 2'd2;
   localparam logic [31:0] HI_MASK = ~((32'd1 << ADDR_BITS) - 32'd1);

   state_t      state;
   logic [1:0]  lat_lane;
   logic [1:0]  lat_size;
   logic        lat_signed;
   logic        lat_write;
   logic [15:0] lat_wdata;

   logic        acc_err;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] ld_data;
   logic [31:0] rmw_data;

   // Request legality, evaluated on the accept cycle
   always_comb begin
      acc_err = 1'b0;
      case (req_size)
         SZ_BYTE: acc_err = 1'b0;
         SZ_HALF: acc_err = req_addr[0];
         SZ_WORD: acc_err = |req_addr[1:0];
         default: acc_err = 1'b1;
      endcase
      if ((req_addr & HI_MASK) != 32'd0) acc_err = 1'b1;
   end

   // Little-endian lane extraction for loads and lane merge for sub-word stores
   always_comb begin
      byte_lane = 8'(dm_rdata >> {lat_lane, 3'b000});
      half_lane = 16'(dm_rdata >> {lat_lane[1], 4'b0000});
      case (lat_size)
         SZ_BYTE: ld_data = {{24{lat_signed & byte_lane[7]}}, byte_lane};
         SZ_HALF: ld_data = {{16{lat_signed & half_lane[15]}}, half_lane};
         default: ld_data = dm_rdata;
      endcase
      rmw_data = dm_rdata;
      if (lat_size == SZ_BYTE) rmw_data[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
      else                     rmw_data[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         dm_we      <= 1'b0;
         dm_addr    <= 32'd0;
         dm_wdata   <= 32'd0;
         dm_pc      <= 32'd0;
         lat_lane   <= 2'd0;
         lat_size   <= 2'd0;
         lat_signed <= 1'b0;
         lat_write  <= 1'b0;
         lat_wdata  <= 16'd0;
      end else begin
         resp_valid <= 1'b0;
         dm_we      <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready  <= 1'b0;
                  lat_lane   <= req_addr[1:0];
                  lat_size   <= req_size;
                  lat_signed <= req_signed;
                  lat_write  <= req_write;
                  lat_wdata  <= req_wdata[15:0];
                  dm_pc      <= req_pc;
                  if (acc_err) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                     state      <= RESP;
                  end else begin
                     dm_addr <= {req_addr[31:2], 2'b00};
                     state   <= ACCESS;
                     // Word stores write directly during ACCESS
                     if (req_write && req_size == SZ_WORD) begin
                        dm_we    <= 1'b1;
                        dm_wdata <= req_wdata;
                     end
                  end
               end
            end
            ACCESS: begin
               if (!lat_write || lat_size == SZ_WORD) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= lat_write ? 32'd0 : ld_data;
                  state      <= RESP;
               end else begin
                  dm_we    <= 1'b1;
                  dm_wdata <= rmw_data;
                  state    <= RMW_WR;
               end
            end
            RMW_WR: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= 32'd0;
               state      <= RESP;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural word memory and a
// response scoreboard.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, req_pc;
   logic        resp_valid, resp_err, dm_we;
   logic [31:0] resp_rdata, dm_addr, dm_wdata, dm_pc, dm_rdata;

   logic [31:0] mem [0:1023];
   logic [32:0] sb [$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;
   assign dm_rdata = mem[dm_addr[11:2]];

   mem_access_ctrl #(.ADDR_BITS(12)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_pc(req_pc),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
      .dm_rdata(dm_rdata)
   );

   // Pop the oldest expected response and compare it against the DUT
   task automatic sb_pop(input string name);
      logic [32:0] e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s: unexpected response err=%0b rdata=%h", name, resp_err, resp_rdata);
      end else begin
         e = sb.pop_front();
         if ({resp_err, resp_rdata} !== e) begin
            bad++;
            $display("FAIL %s: got err=%0b rdata=%h, want err=%0b rdata=%h",
                     name, resp_err, resp_rdata, e[32], e[31:0]);
         end
      end
   endtask

   // Drive one request and wait for its response, measuring latency and writes
   task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        output int lat, output int we_cnt);
      logic got;
      sb.push_back({exp_err, exp_rdata});
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wdata; req_pc = 32'h100 + addr;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s ready: got %0b want 1", name, req_ready);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; we_cnt = 0; got = 1'b0;
      while (!got && lat < 8) begin
         @(negedge clk);
         lat++;
         if (dm_we) begin
            we_cnt++;
            total++;
            if (dm_addr !== {addr[31:2], 2'b00} || dm_pc !== 32'h100 + addr) begin
               bad++;
               $display("FAIL %s dm_addr/pc: got %h/%h want %h/%h", name, dm_addr, dm_pc,
                        {addr[31:2], 2'b00}, 32'h100 + addr);
            end
         end
         if (resp_valid) begin
            got = 1'b1;
            sb_pop(name);
         end
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL %s timeout: no resp_valid within %0d cycles", name, lat);
         void'(sb.pop_front());
      end
   endtask

   task automatic chk_lat(input string name, input int lat, input int we_cnt,
                          input int exp_lat, input int exp_we);
      total++;
      if (lat !== exp_lat || we_cnt !== exp_we) begin
         bad++;
         $display("FAIL %s timing: lat=%0d we=%0d want lat=%0d we=%0d",
                  name, lat, we_cnt, exp_lat, exp_we);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_pc = 32'd0;
      repeat (3) @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_err, dm_we} !== 4'b1000 || resp_rdata !== 32'd0 ||
          dm_addr !== 32'd0 || dm_wdata !== 32'd0 || dm_pc !== 32'd0) begin
         bad++;
         $display("FAIL reset: rdy=%0b rv=%0b err=%0b we=%0b rd=%h a=%h wd=%h pc=%h",
                  req_ready, resp_valid, resp_err, dm_we, resp_rdata, dm_addr, dm_wdata, dm_pc);
      end
      reset = 1'b0;
   endtask

   task automatic test_word;
      int lat, we;
      issue("sw_0x10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 1'b0, 32'd0, lat, we);
      chk_lat("sw_0x10", lat, we, 2, 1);
      issue("lw_0x10", 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0, 32'h12345678, lat, we);
      chk_lat("lw_0x10", lat, we, 2, 0);
      @(negedge clk);
      total++;
      if (resp_rdata !== 32'h12345678 || resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold: rdata=%h rv=%0b want 12345678 rv=0", resp_rdata, resp_valid);
      end
      issue("sw_0x20", 1'b1, 2'd2, 1'b0, 32'h20, 32'hAABBCCDD, 1'b0, 32'd0, lat, we);
      issue("sw_0x40", 1'b1, 2'd2, 1'b0, 32'h40, 32'h80FF7F01, 1'b0, 32'd0, lat, we);
      issue("sw_0x30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, 1'b0, 32'd0, lat, we);
   endtask

   task automatic test_rmw_store;
      int lat, we;
      issue("sb_0x23", 1'b1, 2'd0, 1'b0, 32'h23, 32'h000000EE, 1'b0, 32'd0, lat, we);
      chk_lat("sb_0x23", lat, we, 3, 1);
      @(negedge clk);
      total++;
      if (mem[8] !== 32'hEEBBCCDD) begin
         bad++;
         $display("FAIL sb_mem: got %h want EEBBCCDD", mem[8]);
      end
      issue("sh_0x22", 1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF1234, 1'b0, 32'd0, lat, we);
      chk_lat("sh_0x22", lat, we, 3, 1);
      @(negedge clk);
      total++;
      if (mem[8] !== 32'h1234CCDD) begin
         bad++;
         $display("FAIL sh_mem: got %h want 1234CCDD", mem[8]);
      end
   endtask

   task automatic test_loads;
      int lat, we;
      issue("lb_0x42",  1'b0, 2'd0, 1'b1, 32'h42, 32'h0, 1'b0, 32'hFFFFFFFF, lat, we);
      chk_lat("lb_0x42", lat, we, 2, 0);
      issue("lbu_0x43", 1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 1'b0, 32'h00000080, lat, we);
      issue("lb_0x40",  1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 1'b0, 32'h00000001, lat, we);
      issue("lh_0x40",  1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 1'b0, 32'h00007F01, lat, we);
      issue("lhu_0x42", 1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 1'b0, 32'h000080FF, lat, we);
      issue("lh_0x42",  1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 1'b0, 32'hFFFF80FF, lat, we);
   endtask

   task automatic test_errors;
      int lat, we;
      issue("lw_0x6",   1'b0, 2'd2, 1'b0, 32'h6,    32'h0, 1'b1, 32'd0, lat, we);
      chk_lat("lw_0x6", lat, we, 1, 0);
      issue("sh_0x1",   1'b1, 2'd1, 1'b0, 32'h1,    32'hBEEF, 1'b1, 32'd0, lat, we);
      chk_lat("sh_0x1", lat, we, 1, 0);
      issue("sw_0x1000", 1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 1'b1, 32'd0, lat, we);
      chk_lat("sw_0x1000", lat, we, 1, 0);
      issue("size3",    1'b0, 2'd3, 1'b0, 32'h0,    32'h0, 1'b1, 32'd0, lat, we);
      chk_lat("size3", lat, we, 1, 0);
      issue("lw_ok",    1'b0, 2'd2, 1'b0, 32'h10,   32'h0, 1'b0, 32'h12345678, lat, we);
   endtask

   task automatic test_reset_rmw;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h30; req_wdata = 32'h55; req_pc = 32'h130;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (dm_we !== 1'b1) begin
         bad++;
         $display("FAIL rmw_we: got %0b want 1", dm_we);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({dm_we, req_ready, resp_valid} !== 3'b010) begin
         bad++;
         $display("FAIL rst_rmw: we=%0b rdy=%0b rv=%0b want 0 1 0", dm_we, req_ready, resp_valid);
      end
      @(posedge clk);
      #1;
      total++;
      if (mem[12] !== 32'h11223344) begin
         bad++;
         $display("FAIL rst_mem: got %h want 11223344", mem[12]);
      end
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_quiet: rv=%0b rdy=%0b want 0 1", resp_valid, req_ready);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] addrs [3] = '{32'h10, 32'h40, 32'h20};
      logic [31:0] exps  [3] = '{32'h12345678, 32'h80FF7F01, 32'h1234CCDD};
      int exp_acc [3] = '{0, 3, 6};
      int exp_rsp [3] = '{2, 5, 8};
      int acc [$];
      int rsp [$];
      int k = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = addrs[0];
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (resp_valid) begin
            rsp.push_back(c);
            sb_pop("b2b");
         end
         if (req_valid && req_ready) begin
            acc.push_back(c);
            sb.push_back({1'b0, exps[k]});
            k++;
            @(posedge clk);
            #1;
            if (k < 3) req_addr = addrs[k];
            else       req_valid = 1'b0;
         end
      end
      total++;
      if (acc.size() != 3 || rsp.size() != 3) begin
         bad++;
         $display("FAIL b2b_count: accepts=%0d resps=%0d want 3 3", acc.size(), rsp.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (acc[i] != exp_acc[i] || rsp[i] != exp_rsp[i]) begin
               bad++;
               $display("FAIL b2b_cycle%0d: accept=%0d resp=%0d want %0d %0d",
                        i, acc[i], rsp[i], exp_acc[i], exp_rsp[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_rmw_store();
      test_loads();
      test_errors();
      test_reset_rmw();
      test_back_to_back();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: %0d responses never arrived", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
